prog_freq_gen: RTL and testbench

PROG_FREQ_GEN -- requirements
Module: prog_freq_gen

---
 rtl/freq_gen_pkg.sv | 19 +
 rtl/freq_gen_channel.sv | 154 +++++++++++++++
 rtl/prog_freq_gen.sv | 52 +++++
 tb/tb_prog_freq_gen.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_gen_pkg.sv
// Shared definitions for the programmable frequency generator.
// Holds the power-up channel configuration and the per-channel state encoding.
package freq_gen_pkg;

  // Power-up configuration: 25 MHz / 4 = 6.25 MHz at 50% duty, continuous.
  localparam int DEF_PERIOD = 4;
  localparam int DEF_HIGH   = 2;
  localparam int DEF_BURST  = 0;

  // Shortest period a channel will run; smaller requests are raised to this.
  localparam int MIN_PERIOD = 2;

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_RUN  = 2'd1,
    CH_DONE = 2'd2
  } ch_state_e;

endpackage

// File: rtl/freq_gen_channel.sv
// One waveform channel of the frequency generator.
// A shadow config is written by i_Load; an active config drives the counter.
// Ports:
//   i_Clk, i_Reset  clock and synchronous active-high reset
//   i_Load          write strobe for this channel (already decoded)
//   i_Period/i_High/i_Burst  config values captured on i_Load
//   i_Enable        level-sensitive run enable
//   o_Freq_Out      registered waveform (counter < HIGH)
//   o_Busy          channel running and burst not exhausted
//   o_Burst_Done    one-cycle pulse at the end of a burst
module freq_gen_channel
  import freq_gen_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int BURST_W = 8
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
  input  logic               i_Load,
  input  logic [CNT_W-1:0]   i_Period,
  input  logic [CNT_W-1:0]   i_High,
  input  logic [BURST_W-1:0] i_Burst,
  input  logic               i_Enable,
  output logic               o_Freq_Out,
  output logic               o_Busy,
  output logic               o_Burst_Done
);

  ch_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BURST_W-1:0] bcnt_q, bcnt_d;
  logic [CNT_W-1:0]   sh_period_q, sh_period_d, act_period_q, act_period_d;
  logic [CNT_W-1:0]   sh_high_q, sh_high_d, act_high_q, act_high_d;
  logic [BURST_W-1:0] sh_burst_q, sh_burst_d, act_burst_q, act_burst_d;
  logic               pend_q, pend_d;
  logic               freq_q, freq_d;
  logic               done_q, done_d;
  logic               wrap;
  logic               copy;

  // Active period is only replaced when the counter returns to 0, so the
  // counter can never sit above act_period_q - 1.
  assign wrap = (cnt_q == act_period_q - CNT_W'(1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bcnt_d      = bcnt_q;
    sh_period_d = sh_period_q;
    sh_high_d   = sh_high_q;
    sh_burst_d  = sh_burst_q;
    pend_d      = pend_q | i_Load;
    freq_d      = 1'b0;
    done_d      = 1'b0;
    copy        = 1'b0;

    if (i_Load) begin
      sh_period_d = (i_Period < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : i_Period;
      sh_high_d   = i_High;
      sh_burst_d  = i_Burst;
    end

    case (state_q)
      CH_IDLE: begin
        // Disabled: config follows the shadow with no delay.
        cnt_d  = '0;
        bcnt_d = '0;
        copy   = 1'b1;
        if (i_Enable) state_d = CH_RUN;
      end
      CH_RUN: begin
        if (!i_Enable) begin
          state_d = CH_IDLE;
          cnt_d   = '0;
          bcnt_d  = '0;
          copy    = 1'b1;
        end else begin
          freq_d = (cnt_q < act_high_q);
          if (wrap) begin
            cnt_d = '0;
            if (pend_d) begin
              // New config (including one loaded this very cycle) starts a
              // fresh burst at this period boundary.
              copy   = 1'b1;
              bcnt_d = '0;
            end else if (act_burst_q != '0) begin
              if (bcnt_q + BURST_W'(1) == act_burst_q) begin
                state_d = CH_DONE;
                done_d  = 1'b1;
                bcnt_d  = '0;
              end else begin
                bcnt_d = bcnt_q + BURST_W'(1);
              end
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      CH_DONE: begin
        cnt_d = '0;
        if (!i_Enable) begin
          state_d = CH_IDLE;
          copy    = 1'b1;
        end
      end
      default: begin
        state_d = CH_IDLE;
        cnt_d   = '0;
        bcnt_d  = '0;
      end
    endcase

    act_period_d = copy ? sh_period_d : act_period_q;
    act_high_d   = copy ? sh_high_d   : act_high_q;
    act_burst_d  = copy ? sh_burst_d  : act_burst_q;
    if (copy) pend_d = 1'b0;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q      <= CH_IDLE;
      cnt_q        <= '0;
      bcnt_q       <= '0;
      sh_period_q  <= CNT_W'(DEF_PERIOD);
      sh_high_q    <= CNT_W'(DEF_HIGH);
      sh_burst_q   <= BURST_W'(DEF_BURST);
      act_period_q <= CNT_W'(DEF_PERIOD);
      act_high_q   <= CNT_W'(DEF_HIGH);
      act_burst_q  <= BURST_W'(DEF_BURST);
      pend_q       <= 1'b0;
      freq_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bcnt_q       <= bcnt_d;
      sh_period_q  <= sh_period_d;
      sh_high_q    <= sh_high_d;
      sh_burst_q   <= sh_burst_d;
      act_period_q <= act_period_d;
      act_high_q   <= act_high_d;
      act_burst_q  <= act_burst_d;
      pend_q       <= pend_d;
      freq_q       <= freq_d;
      done_q       <= done_d;
    end
  end

  assign o_Freq_Out   = freq_q;
  assign o_Busy       = (state_q == CH_RUN);
  assign o_Burst_Done = done_q;

endmodule

// File: rtl/prog_freq_gen.sv
// Programmable multi-channel test-waveform generator.
// Decodes the shared load strobe to one channel and instantiates N_CH channels.
// Ports:
//   i_Clk, i_Reset   clock and synchronous active-high reset
//   i_Load, i_Ch_Sel load strobe and target channel (out-of-range ignored)
//   i_Period, i_High, i_Burst  channel config (period clamps to >= 2)
//   i_Enable         per-channel run enable
//   o_Freq_Out, o_Busy, o_Burst_Done  per-channel outputs
module prog_freq_gen #(
  parameter int N_CH    = 2,
  parameter int CNT_W   = 16,
  parameter int BURST_W = 8
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
  input  logic               i_Load,
  input  logic [2:0]         i_Ch_Sel,
  input  logic [CNT_W-1:0]   i_Period,
  input  logic [CNT_W-1:0]   i_High,
  input  logic [BURST_W-1:0] i_Burst,
  input  logic [N_CH-1:0]    i_Enable,
  output logic [N_CH-1:0]    o_Freq_Out,
  output logic [N_CH-1:0]    o_Busy,
  output logic [N_CH-1:0]    o_Burst_Done
);

  logic [N_CH-1:0] load_sel;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      // A select value with no matching channel produces no strobe at all.
      assign load_sel[gi] = i_Load && (i_Ch_Sel == 3'(gi));

      freq_gen_channel #(
        .CNT_W   (CNT_W),
        .BURST_W (BURST_W)
      ) u_ch (
        .i_Clk        (i_Clk),
        .i_Reset      (i_Reset),
        .i_Load       (load_sel[gi]),
        .i_Period     (i_Period),
        .i_High       (i_High),
        .i_Burst      (i_Burst),
        .i_Enable     (i_Enable[gi]),
        .o_Freq_Out   (o_Freq_Out[gi]),
        .o_Busy       (o_Busy[gi]),
        .o_Burst_Done (o_Burst_Done[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_prog_freq_gen.sv
module tb_prog_freq_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [2:0]  ch_sel = 3'd0;
  logic [15:0] period = 16'd0;
  logic [15:0] high = 16'd0;
  logic [7:0]  burst = 8'd0;
  logic [1:0]  en = 2'b00;
  logic [1:0]  freq;
  logic [1:0]  busy;
  logic [1:0]  done;

  int errors = 0;
  int checks = 0;

  prog_freq_gen #(.N_CH(2), .CNT_W(16), .BURST_W(8)) dut (
    .i_Clk        (clk),
    .i_Reset      (rst),
    .i_Load       (load),
    .i_Ch_Sel     (ch_sel),
    .i_Period     (period),
    .i_High       (high),
    .i_Burst      (burst),
    .i_Enable     (en),
    .o_Freq_Out   (freq),
    .o_Busy       (busy),
    .o_Burst_Done (done)
  );

  always #20 clk = ~clk;

  // Expected {freq, busy, done} after the k-th clock edge counted from the
  // edge that first sees the enable high (k = 0). Output shows count k-1,
  // which is (k-1) mod P; a burst of N periods covers counts 0..N*P-1.
  function automatic logic [2:0] model(input int k, input int p, input int h, input int n);
    int  pe;
    logic f, b, d;
    pe = (p < 2) ? 2 : p;
    f  = (k >= 1) && (((k - 1) % pe) < h) && ((n == 0) || (k <= n * pe));
    b  = (n == 0) || (k < n * pe);
    d  = (n != 0) && (k == n * pe);
    return {f, b, d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int ch, input int p, input int h, input int n);
    ch_sel = 3'(ch);
    period = 16'(p);
    high   = 16'(h);
    burst  = 8'(n);
    load   = 1'b1;
    step();
    load   = 1'b0;
  endtask

  task automatic test_reset();
    step();
    step();
    checks++;
    if (freq !== 2'b00) begin errors++; $display("FAIL reset_freq got=%b exp=00", freq); end
    checks++;
    if (busy !== 2'b00) begin errors++; $display("FAIL reset_busy got=%b exp=00", busy); end
    checks++;
    if (done !== 2'b00) begin errors++; $display("FAIL reset_done got=%b exp=00", done); end
    rst = 1'b0;
    step();
    $display("reset: outputs low while reset held");
  endtask

  task automatic test_default_ch0();
    logic [2:0] exp;
    en[0] = 1'b1;
    for (int k = 0; k < 18; k++) begin
      step();
      exp = model(k, 4, 2, 0);
      checks++;
      if ({freq[0], busy[0], done[0]} !== exp) begin
        errors++;
        $display("FAIL default_ch0 k=%0d got(f,b,d)=%b exp=%b", k, {freq[0], busy[0], done[0]}, exp);
      end
    end
    // Counter is mid-period with output high; disabling must drop it next cycle.
    en[0] = 1'b0;
    step();
    checks++;
    if ({freq[0], busy[0], done[0]} !== 3'b000) begin
      errors++;
      $display("FAIL disable_mid got(f,b,d)=%b exp=000", {freq[0], busy[0], done[0]});
    end
    $display("default ch0: P=4 H=2 continuous, then mid-period disable");
  endtask

  task automatic test_burst_ch1();
    logic [2:0] exp;
    int pulses, dones;
    logic prev;
    pulses = 0; dones = 0; prev = 1'b0;
    do_load(1, 10, 3, 5);
    en[1] = 1'b1;
    for (int k = 0; k < 62; k++) begin
      step();
      exp = model(k, 10, 3, 5);
      checks++;
      if ({freq[1], busy[1], done[1]} !== exp) begin
        errors++;
        $display("FAIL burst_ch1 k=%0d got(f,b,d)=%b exp=%b", k, {freq[1], busy[1], done[1]}, exp);
      end
      if (freq[1] && !prev) pulses++;
      if (done[1]) dones++;
      prev = freq[1];
    end
    checks++;
    if (pulses != 5) begin errors++; $display("FAIL burst_pulses got=%0d exp=5", pulses); end
    checks++;
    if (dones != 1) begin errors++; $display("FAIL burst_done_count got=%0d exp=1", dones); end
    en[1] = 1'b0;
    step();
    $display("burst ch1: P=10 H=3 N=5 pulses=%0d done_pulses=%0d", pulses, dones);
  endtask

  task automatic test_reload();
    logic [2:0] exp;
    int kl, w;
    kl = int'($urandom_range(9, 16));
    w  = ((kl + 7) / 8) * 8;
    do_load(0, 8, 4, 0);
    en[0] = 1'b1;
    for (int k = 0; k < 42; k++) begin
      step();
      exp = (k <= w) ? model(k, 8, 4, 0) : model(k - w, 6, 1, 0);
      checks++;
      if ({freq[0], busy[0], done[0]} !== exp) begin
        errors++;
        $display("FAIL reload k=%0d got(f,b,d)=%b exp=%b", k, {freq[0], busy[0], done[0]}, exp);
      end
      if (k == kl - 1) begin
        ch_sel = 3'd0; period = 16'd6; high = 16'd1; burst = 8'd0; load = 1'b1;
      end
      if (k == kl) load = 1'b0;
    end
    en[0] = 1'b0;
    step();
    $display("reload ch0: P=8 H=4 -> P=6 H=1 load at edge %0d, switch at wrap %0d", kl, w);
  endtask

  task automatic test_chsel_ignore();
    logic [2:0] exp0, exp1;
    do_load(7, 3, 1, 0);
    en = 2'b11;
    for (int k = 0; k < 30; k++) begin
      step();
      exp0 = model(k, 6, 1, 0);
      exp1 = model(k, 10, 3, 5);
      checks++;
      if ({freq[0], busy[0], done[0]} !== exp0) begin
        errors++;
        $display("FAIL chsel7_ch0 k=%0d got(f,b,d)=%b exp=%b", k, {freq[0], busy[0], done[0]}, exp0);
      end
      checks++;
      if ({freq[1], busy[1], done[1]} !== exp1) begin
        errors++;
        $display("FAIL chsel7_ch1 k=%0d got(f,b,d)=%b exp=%b", k, {freq[1], busy[1], done[1]}, exp1);
      end
    end
    en = 2'b00;
    step();
    $display("ch_sel=7 load: both channels keep their configs");
  endtask

  task automatic test_edges();
    int ep[5] = '{6, 10, 1, 1, 3};
    int eh[5] = '{0, 20, 1, 0, 3};
    int eb[5] = '{0, 0, 0, 2, 2};
    logic [2:0] exp;
    for (int i = 0; i < 5; i++) begin
      do_load(0, ep[i], eh[i], eb[i]);
      en[0] = 1'b1;
      for (int k = 0; k < 24; k++) begin
        step();
        exp = model(k, ep[i], eh[i], eb[i]);
        checks++;
        if ({freq[0], busy[0], done[0]} !== exp) begin
          errors++;
          $display("FAIL edge%0d k=%0d got(f,b,d)=%b exp=%b", i, k, {freq[0], busy[0], done[0]}, exp);
        end
      end
      en[0] = 1'b0;
      step();
      $display("edge cfg: P=%0d H=%0d N=%0d", ep[i], eh[i], eb[i]);
    end
  endtask

  task automatic test_random();
    logic [2:0] exp;
    int ch, p, h, n, pe, ncyc;
    for (int it = 0; it < 20; it++) begin
      ch = int'($urandom_range(0, 1));
      p  = int'($urandom_range(1, 12));
      h  = int'($urandom_range(0, 14));
      n  = int'($urandom_range(0, 4));
      pe = (p < 2) ? 2 : p;
      ncyc = (n == 0) ? 3 * pe + 2 : n * pe + 4;
      do_load(ch, p, h, n);
      en[ch] = 1'b1;
      for (int k = 0; k < ncyc; k++) begin
        step();
        exp = model(k, p, h, n);
        checks++;
        if ({freq[ch], busy[ch], done[ch]} !== exp) begin
          errors++;
          $display("FAIL random%0d ch=%0d k=%0d got(f,b,d)=%b exp=%b", it, ch, k, {freq[ch], busy[ch], done[ch]}, exp);
        end
      end
      en[ch] = 1'b0;
      step();
      $display("random %0d: ch=%0d P=%0d H=%0d N=%0d cycles=%0d", it, ch, p, h, n, ncyc);
    end
  endtask

  task automatic test_reset_midburst();
    logic [2:0] exp;
    do_load(1, 7, 3, 6);
    en[1] = 1'b1;
    for (int k = 0; k < 20; k++) step();
    rst = 1'b1;
    ch_sel = 3'd1; period = 16'd9; high = 16'd5; burst = 8'd1; load = 1'b1;
    step();
    checks++;
    if ({freq, busy, done} !== 6'b000000) begin
      errors++;
      $display("FAIL reset_midburst got(f,b,d)=%b exp=000000", {freq, busy, done});
    end
    rst = 1'b0;
    load = 1'b0;
    for (int k = 0; k < 16; k++) begin
      step();
      exp = model(k, 4, 2, 0);
      checks++;
      if ({freq[1], busy[1], done[1]} !== exp) begin
        errors++;
        $display("FAIL reset_defaults k=%0d got(f,b,d)=%b exp=%b", k, {freq[1], busy[1], done[1]}, exp);
      end
    end
    en[1] = 1'b0;
    step();
    $display("reset mid-burst with load: outputs cleared, defaults P=4 H=2 restored");
  endtask

  initial begin
    test_reset();
    test_default_ch0();
    test_burst_ch1();
    test_reload();
    test_chsel_ignore();
    test_edges();
    test_random();
    test_reset_midburst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
